uart_tx_stream: RTL
===================

Name: uart_tx_stream

Overview:
- Single-clock UART transmitter that serialises 8-bit bytes onto `tx` at BAUD_RATE, using an internal baud counter. It needs no divided clock.
- A valid/ready byte interface feeds a small internal FIFO, so a producer can queue several bytes and the line sends them back-to-back.
- It is the transmit-side counterpart to the byte receiver. Receiver output bytes can be fed straight in, or produced by other logic.

Parameters:
- CLOCK_RATE, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate. BIT_TICKS = CLOCK_RATE/BAUD_RATE (integer division, must be >= 2).
- FIFO_DEPTH, 4, byte queue depth. Power of two, >= 2.
- STOP_BITS, 1, number of stop bits (1 or 2).
- PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd). Ignored otherwise.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- data  in  8  byte to transmit; sampled only on acceptance.
- dataValid  in  1  producer has a byte on `data`.
- dataReady  out  1  FIFO can accept a byte this cycle.
- tx  out  1  serial line, idle high; driven directly from a flop.
- busy  out  1  frame in progress or FIFO non-empty.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst high at posedge): tx=1, state=IDLE, FIFO flushed, level=0, busy=0, baud and bit counters cleared.
  - dataReady=0 while rst is high.
  - Reset mid-frame truncates the frame: tx is 1 after that edge, and the byte is discarded.
- Handshake:
  - dataReady = !rst && (level < FIFO_DEPTH). It is combinational from registered level and never depends on dataValid.
  - A byte is accepted on a posedge with dataValid && dataReady.
  - `data` may change freely after acceptance.
- FIFO behaviour:
  - A push and a pop at the same edge both take effect, and level is unchanged.
  - When full, dataReady=0, even if a pop occurs that edge; no overwrite.
- FSM states: IDLE, START, DATA, PARITY (only if compiled in), STOP.
- IDLE:
  - tx=1.
  - If level>0 at a posedge: pop the head into the shift register, go to START, set tx<=0 and clear the baud counter.
  - First start-bit cycle is exactly one cycle after the accepting edge when the FIFO was empty and the FSM was idle.
- START: holds tx=0 for BIT_TICKS cycles, then goes to DATA with bit 0 on tx.
- DATA: 8 bits, LSB first, each held BIT_TICKS cycles. After bit 7, goes to PARITY (if enabled) or STOP.
- STOP: tx=1 for STOP_BITS*BIT_TICKS cycles. At the end:
  - If level>0: pop and go directly to START, so tx falls on the cycle after the last stop cycle, with no extra idle gap.
  - Otherwise go to IDLE.
- Baud counter: counts 0..BIT_TICKS-1 within each bit and wraps at each bit boundary. Bit boundaries are exact multiples of BIT_TICKS from the start-bit edge, with no drift.
- Frame length: (10 + STOP_BITS - 1) bit periods without parity, plus one with parity.
- busy = (state != IDLE) || (level != 0).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP and lasts BIT_TICKS cycles.
  - Parity bit = ^byte when PARITY_ODD=0 (even parity); ~^byte when PARITY_ODD=1.
  - Frame length grows by one bit period.
- Undefined: no PARITY state and no parity logic. PARITY_ODD is unused; frame goes DATA -> STOP.

Test Plan:
- Single byte (CLOCK_RATE=16, BAUD_RATE=1, so BIT_TICKS=16): push 0x55 into an idle block -> tx low starting 1 cycle after the accept edge, then 1,0,1,0,1,0,1,0 for 16 cycles each, then high 16 cycles; busy drops after 160 cycles; level returns to 0.
- Burst, FIFO_DEPTH=4, BIT_TICKS=16: push 0x01..0x05 on 5 consecutive cycles from empty -> all 5 accepted, dataReady=0 after the 5th accept. Five contiguous 160-cycle frames follow, with no high gap between a stop bit and the next start; bytes appear in order.
- Backpressure: hold dataValid=1 with 0xAA while full -> no accept until the first pop; 0xAA is transmitted exactly once.
- Reset mid-frame: assert rst during DATA bit 3 of 0xF0 with 2 bytes queued -> tx=1, level=0, busy=0 after the edge; no further frames follow after rst drops.
- STOP_BITS=2: send 0x00 -> tx is 0 for 144 cycles, then high 32 cycles before busy=0.
- With UART_TX_PARITY_EN:
  - PARITY_ODD=0, send 0x07 -> parity bit 1; frame is 176 cycles.
  - PARITY_ODD=1, send 0x03 -> parity bit 1.

Source files
------------

// File: rtl/uart_tx_stream.sv
// UART byte transmitter with valid/ready input FIFO and internal baud counter.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_stream #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data,
  input  logic                          dataValid,
  output logic                          dataReady,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BIT_TICKS = CLOCK_RATE / BAUD_RATE;
  localparam int CW = $clog2(BIT_TICKS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(BIT_TICKS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  if (BIT_TICKS < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2)
  begin : gBadCfg
    $error("uart_tx_stream: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [7:0]    head;
  logic          push;
  logic          pop;

  state_t        state;
  logic [CW-1:0] tick;
  logic [2:0]    bitCnt;
  logic [7:0]    shift;
  logic          tickEnd;
  logic          stopEnd;
`ifdef UART_TX_PARITY_EN
  logic          parBit;
`endif

  assign dataReady = !rst && (level < LW'(FIFO_DEPTH));
  assign push      = dataValid && dataReady;
  assign head      = mem[rdPtr];
  assign tickEnd   = (tick == LAST_TICK);
  assign stopEnd   = (state == STOP) && tickEnd && (bitCnt == STOP_LAST);
  // A new frame may start from idle or straight out of the last stop tick.
  assign pop       = (level != '0) && ((state == IDLE) || stopEnd);
  assign busy      = (state != IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tx     <= 1'b1;
      tick   <= '0;
      bitCnt <= '0;
      shift  <= '0;
`ifdef UART_TX_PARITY_EN
      parBit <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          tx   <= 1'b1;
          tick <= '0;
          if (pop) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            parBit <= (^head) ^ 1'(PARITY_ODD);
`endif
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tickEnd) begin
            tick   <= '0;
            bitCnt <= '0;
            tx     <= shift[0];
            shift  <= {1'b0, shift[7:1]};
            state  <= DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tickEnd) begin
            tick <= '0;
            if (bitCnt == 3'd7) begin
              bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx    <= parBit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bitCnt <= bitCnt + 1'b1;
              tx     <= shift[0];
              shift  <= {1'b0, shift[7:1]};
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tickEnd) begin
            tick   <= '0;
            bitCnt <= '0;
            tx     <= 1'b1;
            state  <= STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tickEnd) begin
            tick <= '0;
            if (bitCnt == STOP_LAST) begin
              bitCnt <= '0;
              if (pop) begin
                shift <= head;
`ifdef UART_TX_PARITY_EN
                parBit <= (^head) ^ 1'(PARITY_ODD);
`endif
                tx    <= 1'b0;
                state <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
